// File: rtl/data_memory_lsu.sv
// Byte-addressed, lane-aware data memory with a valid/ready request channel
// and a one-entry registered response (load extension, alignment checking).
module data_memory_lsu #(
  parameter int D = 6,
  parameter int W = 32,
  localparam int OFFS = $clog2(W / 8),
  localparam int AW = D + OFFS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [W-1:0]  req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [W-1:0]  resp_rdata,
  output logic          resp_err
);

  localparam int NB = W / 8;
  localparam int LW = $clog2(W);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [W-1:0]    mem_q [2**D];
  logic [0:0]      state_q, state_d;
  logic [W-1:0]    rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [D-1:0]    idx;
  logic [OFFS-1:0] lane;
  int unsigned     nbytes, lane_n;
  logic            err, accept, we, sign;
  logic [NB-1:0]   be;
  logic [LW-1:0]   sbit;
  logic [W-1:0]    wshift, rshift, keep, ld_ext;

  assign idx    = req_addr[AW-1:OFFS];
  assign lane   = req_addr[OFFS-1:0];
  assign accept = req_valid && req_ready;
  // rst_n gating keeps a presented store from landing while reset is held.
  assign we     = accept && req_write && !err && rst_n;

  assign req_ready  = (state_q == EMPTY) || resp_ready;
  assign resp_valid = (state_q == FULL);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    nbytes = 32'd1 << req_size;
    lane_n = 32'(lane);
    err    = (nbytes > NB) || ((lane_n & (nbytes - 1)) != 0);
    be     = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      be[b] = (b >= lane_n) && (b < lane_n + nbytes);
    end
    wshift = req_wdata << (8 * lane_n);
    rshift = mem_q[idx] >> (8 * lane_n);
    keep   = '1;
    sign   = 1'b0;
    sbit   = LW'(8 * nbytes - 1);
    // Full-width loads bypass extension; narrower ones mask then sign-fill.
    if (nbytes < NB) begin
      keep = {W{1'b1}} >> (W - 8 * nbytes);
      sign = !req_unsigned && rshift[sbit];
    end
    ld_ext = (rshift & keep) | (sign ? ~keep : '0);
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      state_d = FULL;
      err_d   = err;
      rdata_d = (req_write || err) ? '0 : ld_ext;
    end else if (resp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed self-checking bench for data_memory_lsu (D=6, W=32).
module tb_data_memory_lsu;

  localparam int D  = 6;
  localparam int W  = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [W-1:0]  resp_rdata;

  int tests = 0;
  int fails = 0;

  data_memory_lsu #(.D(D), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [AW-1:0] a, input logic [W-1:0] wd);
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; resp_ready = 1'b1; idle();
    req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    tick(); tick();
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", resp_valid); end
    tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", resp_err); end
    rst_n = 1'b1; #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", req_ready); end
    tick();
  endtask

  task automatic test_word();
    drive(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF); tick();
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      fails++; $display("FAIL store_resp got v=%b d=%h e=%b want v=1 d=0 e=0", resp_valid, resp_rdata, resp_err); end
    idle(); tick();
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL idle_drain got %b want 0", resp_valid); end
    drive(1'b0, 2'd2, 1'b0, 8'h10, 32'h0); tick();
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0) begin
      fails++; $display("FAIL word_load got v=%b d=%h e=%b want v=1 d=deadbeef e=0", resp_valid, resp_rdata, resp_err); end
    idle(); tick();
  endtask

  task automatic test_byte();
    logic [W-1:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hDEAD80EF, 32'hFFFFDEAD};
    drive(1'b1, 2'd0, 1'b0, 8'h11, 32'hFFFFFF80); tick();
    drive(1'b0, 2'd0, 1'b0, 8'h11, '0); tick();
    tests++; if (resp_rdata !== exp[0]) begin fails++; $display("FAIL lb_signed got %h want %h", resp_rdata, exp[0]); end
    drive(1'b0, 2'd0, 1'b1, 8'h11, '0); tick();
    tests++; if (resp_rdata !== exp[1]) begin fails++; $display("FAIL lb_unsigned got %h want %h", resp_rdata, exp[1]); end
    drive(1'b0, 2'd2, 1'b0, 8'h10, '0); tick();
    tests++; if (resp_rdata !== exp[2]) begin fails++; $display("FAIL lanes_intact got %h want %h", resp_rdata, exp[2]); end
    drive(1'b0, 2'd1, 1'b0, 8'h12, '0); tick();
    tests++; if (resp_rdata !== exp[3]) begin fails++; $display("FAIL lh_signed got %h want %h", resp_rdata, exp[3]); end
    idle(); tick();
  endtask

  task automatic test_misaligned();
    drive(1'b0, 2'd1, 1'b0, 8'h13, '0); tick();
    tests++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0 || resp_valid !== 1'b1) begin
      fails++; $display("FAIL lh_misaligned got v=%b e=%b d=%h want v=1 e=1 d=0", resp_valid, resp_err, resp_rdata); end
    drive(1'b0, 2'd3, 1'b0, 8'h10, '0); tick();
    tests++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      fails++; $display("FAIL oversize_load got e=%b d=%h want e=1 d=0", resp_err, resp_rdata); end
    drive(1'b1, 2'd3, 1'b0, 8'h10, 32'h0); tick();
    tests++; if (resp_err !== 1'b1) begin fails++; $display("FAIL oversize_store got e=%b want 1", resp_err); end
    drive(1'b1, 2'd1, 1'b0, 8'h11, 32'h1234); tick();
    tests++; if (resp_err !== 1'b1) begin fails++; $display("FAIL sh_misaligned got e=%b want 1", resp_err); end
    drive(1'b0, 2'd2, 1'b0, 8'h10, '0); tick();
    tests++; if (resp_rdata !== 32'hDEAD80EF || resp_err !== 1'b0) begin
      fails++; $display("FAIL err_no_effect got d=%h e=%b want d=dead80ef e=0", resp_rdata, resp_err); end
    idle(); tick();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 2'd2, 1'b0, 8'h20, 32'h11111111); tick();
    drive(1'b1, 2'd2, 1'b0, 8'h24, 32'h22222222); tick();
    idle(); tick();
    resp_ready = 1'b0;
    drive(1'b0, 2'd2, 1'b0, 8'h10, '0); tick();
    drive(1'b0, 2'd2, 1'b0, 8'h20, '0);
    for (int i = 0; i < 2; i++) begin
      tests++; if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD80EF) begin
        fails++; $display("FAIL bp_hold%0d got rdy=%b v=%b d=%h want rdy=0 v=1 d=dead80ef", i, req_ready, resp_valid, resp_rdata); end
      tick();
    end
    resp_ready = 1'b1; tick();
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h11111111) begin
      fails++; $display("FAIL bp_second got v=%b d=%h want v=1 d=11111111", resp_valid, resp_rdata); end
    drive(1'b0, 2'd2, 1'b0, 8'h24, '0); tick();
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h22222222) begin
      fails++; $display("FAIL bp_third got v=%b d=%h want v=1 d=22222222", resp_valid, resp_rdata); end
    idle(); tick();
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", resp_valid); end
  endtask

  task automatic test_back_to_back();
    int resps = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(1'b1, 2'd2, 1'b0, 8'h30, 32'h10000000 + i);
      else            drive(1'b0, 2'd2, 1'b0, 8'h30, '0);
      #3;
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL stream_ready%0d got %b want 1", i, req_ready); end
      tick();
      if (resp_valid === 1'b1) resps++;
      if (i % 2 == 1) begin
        tests++; if (resp_rdata !== 32'h10000000 + i - 1) begin
          fails++; $display("FAIL stream_load%0d got %h want %h", i, resp_rdata, 32'h10000000 + i - 1); end
      end
    end
    tests++; if (resps != 8) begin fails++; $display("FAIL stream_count got %0d want 8", resps); end
    idle(); tick();
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    drive(1'b0, 2'd2, 1'b0, 8'h30, '0); tick();
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h10000006) begin
      fails++; $display("FAIL rst_pre got v=%b d=%h want v=1 d=10000006", resp_valid, resp_rdata); end
    drive(1'b1, 2'd2, 1'b0, 8'h10, 32'hBADBAD00);
    rst_n = 1'b0; #1;
    tests++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
      fails++; $display("FAIL rst_async got v=%b d=%h want v=0 d=0", resp_valid, resp_rdata); end
    tick(); tick();
    idle(); rst_n = 1'b1; resp_ready = 1'b1; tick();
    drive(1'b0, 2'd2, 1'b0, 8'h10, '0); tick();
    tests++; if (resp_rdata !== 32'hDEAD80EF) begin fails++; $display("FAIL rst_no_write got %h want dead80ef", resp_rdata); end
    drive(1'b0, 2'd2, 1'b0, 8'h30, '0); tick();
    tests++; if (resp_rdata !== 32'h10000006) begin fails++; $display("FAIL rst_retained got %h want 10000006", resp_rdata); end
    idle(); tick();
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_misaligned();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
